// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding, owner encoding
// and the burst-counter width helper.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        EXT_RD = 2'd2,
        WR     = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_EXT = 1'b1
    } owner_t;

    // The counter must be able to hold MAX_BURST itself.
    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, external-requester and data-memory signals of the arbiter, bundled
// with a slave view for the arbiter and a master view for its environment.
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic                  cpu_type;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_gnt;
    logic                  cpu_rvalid;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_stall;

    logic                  ext_req;
    logic                  ext_we;
    logic                  ext_type;
    logic                  ext_lock;
    logic [ADDR_WIDTH-1:0] ext_addr;
    logic [DATA_WIDTH-1:0] ext_wdata;
    logic                  ext_gnt;
    logic                  ext_rvalid;
    logic [DATA_WIDTH-1:0] ext_rdata;

    logic                  mem_en;
    logic                  mem_we;
    logic                  mem_type;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_type, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
        input  ext_req, ext_we, ext_type, ext_lock, ext_addr, ext_wdata,
        output ext_gnt, ext_rvalid, ext_rdata,
        output mem_en, mem_we, mem_type, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_type, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
        output ext_req, ext_we, ext_type, ext_lock, ext_addr, ext_wdata,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  mem_en, mem_we, mem_type, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arb_prio.sv
// Combinational grant decision: locked external burst first, then
// alternation on a tie, then whichever side is requesting alone.
module dmem_arb_prio
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 5
) (
    input  logic             cpu_req,
    input  logic             ext_req,
    input  logic             ext_lock,
    input  owner_t           last_owner,
    input  logic [CNT_W-1:0] burst_cnt,
    output logic             cpu_sel,
    output logic             ext_sel
);

    logic lock_active;

    // Lock only extends a burst the external side already owns; once the
    // count hits MAX_BURST it lapses so a waiting CPU gets its turn.
    assign lock_active = ext_lock && ext_req && (last_owner == OWN_EXT)
                         && (burst_cnt < CNT_W'(MAX_BURST));

    always_comb begin
        cpu_sel = 1'b0;
        ext_sel = 1'b0;
        if (lock_active) begin
            ext_sel = 1'b1;
        end else if (cpu_req && ext_req) begin
            if (last_owner == OWN_CPU) begin
                ext_sel = 1'b1;
            end else begin
                cpu_sel = 1'b1;
            end
        end else if (cpu_req) begin
            cpu_sel = 1'b1;
        end else if (ext_req) begin
            ext_sel = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: same-cycle grant and command mux, one-cycle
// read response routed back to the requester that issued the read.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic            clk,
    input  logic            rst,
    dmem_arbiter_if.slave   bus
);

    localparam int CNT_W = cnt_width(MAX_BURST);

    arb_state_t       state_reg, state_next;
    owner_t           last_owner_reg, last_owner_next;
    logic [CNT_W-1:0] burst_cnt_reg, burst_cnt_next;

    logic                  cpu_sel, ext_sel;
    logic                  cpu_gnt, ext_gnt;
    logic                  cpu_rvalid, ext_rvalid;
    logic [ADDR_WIDTH-1:0] addr_mux;
    logic [DATA_WIDTH-1:0] wdata_mux;

    dmem_arb_prio #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_prio (
        .cpu_req    (bus.cpu_req),
        .ext_req    (bus.ext_req),
        .ext_lock   (bus.ext_lock),
        .last_owner (last_owner_reg),
        .burst_cnt  (burst_cnt_reg),
        .cpu_sel    (cpu_sel),
        .ext_sel    (ext_sel)
    );

    // Grants are masked while reset is held so nothing issues in that cycle.
    assign cpu_gnt = rst & cpu_sel;
    assign ext_gnt = rst & ext_sel;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            last_owner_reg <= OWN_EXT;
            burst_cnt_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            last_owner_reg <= last_owner_next;
            burst_cnt_reg  <= burst_cnt_next;
        end
    end

    always_comb begin
        state_next      = IDLE;
        last_owner_next = last_owner_reg;
        burst_cnt_next  = '0;
        cpu_rvalid      = 1'b0;
        ext_rvalid      = 1'b0;

        if (cpu_gnt) begin
            state_next      = bus.cpu_we ? WR : CPU_RD;
            last_owner_next = OWN_CPU;
        end else if (ext_gnt) begin
            state_next      = bus.ext_we ? WR : EXT_RD;
            last_owner_next = OWN_EXT;
        end

        // A full count always wraps to zero, which voids the lock for one cycle.
        if (burst_cnt_reg != CNT_W'(MAX_BURST) && ext_gnt && bus.ext_lock) begin
            burst_cnt_next = burst_cnt_reg + CNT_W'(1);
        end

        case (state_reg)
            CPU_RD:  cpu_rvalid = rst;
            EXT_RD:  ext_rvalid = rst;
            default: ;
        endcase
    end

    assign addr_mux  = ext_gnt ? bus.ext_addr  : bus.cpu_addr;
    assign wdata_mux = ext_gnt ? bus.ext_wdata : bus.cpu_wdata;

    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.ext_gnt    = ext_gnt;
    assign bus.cpu_rvalid = cpu_rvalid;
    assign bus.ext_rvalid = ext_rvalid;
    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.ext_rdata  = bus.mem_rdata;
    assign bus.cpu_stall  = rst & bus.cpu_req & ~cpu_gnt;

    assign bus.mem_en    = cpu_gnt | ext_gnt;
    assign bus.mem_we    = (cpu_gnt & bus.cpu_we) | (ext_gnt & bus.ext_we);
    assign bus.mem_type  = ext_gnt ? bus.ext_type : bus.cpu_type;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: inputs change on the falling edge, outputs
// are checked 2 ns later, well away from the rising edge.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    dmem_arbiter #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .MAX_BURST  (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic clear_inputs();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_type = 1'b0;
        bus.cpu_addr = '0;  bus.cpu_wdata = '0;
        bus.ext_req = 1'b0; bus.ext_we = 1'b0; bus.ext_type = 1'b0; bus.ext_lock = 1'b0;
        bus.ext_addr = '0;  bus.ext_wdata = '0;
        bus.mem_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.cpu_req = 1'b1;
        bus.ext_req = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #2;
            checks++;
            if ({bus.cpu_gnt, bus.ext_gnt, bus.mem_en, bus.mem_we} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_grants cyc%0d: got %b expected 0000", c,
                         {bus.cpu_gnt, bus.ext_gnt, bus.mem_en, bus.mem_we});
            end
            checks++;
            if ({bus.cpu_rvalid, bus.ext_rvalid, bus.cpu_stall} !== 3'b000) begin
                errors++;
                $display("FAIL reset_rvalid_stall cyc%0d: got %b expected 000", c,
                         {bus.cpu_rvalid, bus.ext_rvalid, bus.cpu_stall});
            end
        end
        $display("reset: grants, rvalid and stall held low");
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
    endtask

    task automatic test_cpu_read();
        do_reset();
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h100;
        #2;
        checks++;
        if ({bus.cpu_gnt, bus.ext_gnt, bus.mem_en, bus.mem_we, bus.cpu_stall} !== 5'b10100) begin
            errors++;
            $display("FAIL cpu_read_issue: got %b expected 10100",
                     {bus.cpu_gnt, bus.ext_gnt, bus.mem_en, bus.mem_we, bus.cpu_stall});
        end
        checks++;
        if (bus.mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL cpu_read_addr: got %h expected 00000100", bus.mem_addr);
        end
        @(negedge clk);
        bus.cpu_req = 1'b0;
        bus.mem_rdata = 32'hDEADBEEF;
        #2;
        checks++;
        if ({bus.cpu_rvalid, bus.ext_rvalid} !== 2'b10 || bus.cpu_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL cpu_read_resp: got rvalid=%b rdata=%h expected 10 deadbeef",
                     {bus.cpu_rvalid, bus.ext_rvalid}, bus.cpu_rdata);
        end
        @(negedge clk);
        #2;
        checks++;
        if (bus.cpu_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read_single_resp: got %b expected 0", bus.cpu_rvalid);
        end
        $display("cpu_read: addr=100 rdata=%h", bus.cpu_rdata);
        clear_inputs();
    endtask

    task automatic test_tie();
        logic [2:0] exp_cpu;
        logic [2:0] exp_ext;
        logic [2:0] exp_stall;
        exp_cpu   = 3'b101;
        exp_ext   = 3'b010;
        exp_stall = 3'b010;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.cpu_req = 1'b1; bus.ext_req = 1'b1;
            bus.cpu_addr = 32'h10 + c; bus.ext_addr = 32'h20 + c;
            bus.mem_rdata = 32'hA000_0000 + c;
            #2;
            checks++;
            if (bus.cpu_gnt !== exp_cpu[c] || bus.ext_gnt !== exp_ext[c] ||
                bus.cpu_stall !== exp_stall[c]) begin
                errors++;
                $display("FAIL tie_cyc%0d: got cpu_gnt=%b ext_gnt=%b stall=%b expected %b %b %b",
                         c, bus.cpu_gnt, bus.ext_gnt, bus.cpu_stall,
                         exp_cpu[c], exp_ext[c], exp_stall[c]);
            end
            // Back-to-back: the previous cycle's read response arrives alongside the new grant.
            if (c > 0) begin
                checks++;
                if (bus.cpu_rvalid !== exp_cpu[c-1] || bus.ext_rvalid !== exp_ext[c-1]) begin
                    errors++;
                    $display("FAIL tie_rvalid_cyc%0d: got cpu=%b ext=%b expected %b %b",
                             c, bus.cpu_rvalid, bus.ext_rvalid, exp_cpu[c-1], exp_ext[c-1]);
                end
            end
            $display("tie cyc%0d: cpu_gnt=%b ext_gnt=%b stall=%b mem_addr=%h",
                     c, bus.cpu_gnt, bus.ext_gnt, bus.cpu_stall, bus.mem_addr);
        end
        @(negedge clk);
        clear_inputs();
        #2;
        checks++;
        if (bus.cpu_rvalid !== 1'b1 || bus.ext_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL tie_last_resp: got cpu=%b ext=%b expected 1 0",
                     bus.cpu_rvalid, bus.ext_rvalid);
        end
    endtask

    task automatic test_burst();
        int first_cpu;
        logic exp_ext;
        first_cpu = -1;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus.cpu_req = 1'b1; bus.ext_req = 1'b1; bus.ext_lock = 1'b1;
            #2;
            exp_ext = (c != 16);
            checks++;
            if (bus.ext_gnt !== exp_ext || bus.cpu_gnt !== !exp_ext) begin
                errors++;
                $display("FAIL burst_cyc%0d: got cpu_gnt=%b ext_gnt=%b expected %b %b",
                         c, bus.cpu_gnt, bus.ext_gnt, !exp_ext, exp_ext);
            end
            if (bus.cpu_gnt === 1'b1 && first_cpu < 0) first_cpu = c;
            $display("burst cyc%0d: cpu_gnt=%b ext_gnt=%b", c, bus.cpu_gnt, bus.ext_gnt);
        end
        checks++;
        if (first_cpu < 0 || first_cpu > 16) begin
            errors++;
            $display("FAIL burst_cpu_wait: got first cpu grant at %0d expected <=16", first_cpu);
        end
        clear_inputs();
    endtask

    task automatic test_write();
        do_reset();
        @(negedge clk);
        bus.ext_req = 1'b1; bus.ext_we = 1'b1; bus.ext_type = 1'b1;
        bus.ext_addr = 32'h23; bus.ext_wdata = 32'hAB;
        bus.cpu_addr = 32'h77; bus.cpu_wdata = 32'h55;
        #2;
        checks++;
        if ({bus.ext_gnt, bus.cpu_gnt, bus.mem_en, bus.mem_we, bus.mem_type} !== 5'b10111) begin
            errors++;
            $display("FAIL write_ctrl: got %b expected 10111",
                     {bus.ext_gnt, bus.cpu_gnt, bus.mem_en, bus.mem_we, bus.mem_type});
        end
        checks++;
        if (bus.mem_addr !== 32'h23 || bus.mem_wdata !== 32'hAB) begin
            errors++;
            $display("FAIL write_data: got addr=%h wdata=%h expected 00000023 000000ab",
                     bus.mem_addr, bus.mem_wdata);
        end
        $display("write: addr=%h wdata=%h", bus.mem_addr, bus.mem_wdata);
        @(negedge clk);
        clear_inputs();
        #2;
        checks++;
        if ({bus.ext_rvalid, bus.cpu_rvalid, bus.mem_en, bus.mem_we} !== 4'b0000) begin
            errors++;
            $display("FAIL write_no_resp: got %b expected 0000",
                     {bus.ext_rvalid, bus.cpu_rvalid, bus.mem_en, bus.mem_we});
        end
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_addr = 32'h40;
        #2;
        checks++;
        if (bus.cpu_gnt !== 1'b1) begin
            errors++;
            $display("FAIL midrst_issue: got cpu_gnt=%b expected 1", bus.cpu_gnt);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.ext_req = 1'b1;
        #2;
        checks++;
        if ({bus.cpu_rvalid, bus.cpu_gnt, bus.ext_gnt, bus.mem_en} !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_t1: got rvalid,gnts,mem_en=%b expected 0000",
                     {bus.cpu_rvalid, bus.cpu_gnt, bus.ext_gnt, bus.mem_en});
        end
        @(negedge clk);
        rst = 1'b1;
        #2;
        checks++;
        if ({bus.cpu_rvalid, bus.ext_rvalid, bus.cpu_gnt, bus.ext_gnt} !== 4'b0010) begin
            errors++;
            $display("FAIL midrst_t2: got rvalid cpu,ext gnt cpu,ext=%b expected 0010",
                     {bus.cpu_rvalid, bus.ext_rvalid, bus.cpu_gnt, bus.ext_gnt});
        end
        $display("reset_mid_read: post-reset tie cpu_gnt=%b ext_gnt=%b", bus.cpu_gnt, bus.ext_gnt);
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_cpu_read();
        test_tie();
        test_burst();
        test_write();
        test_reset_mid_read();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data width of every data port.
REQ-002 Parameter ADDR_WIDTH, default 32, SHALL set the width of every address port.
REQ-003 Parameter MAX_BURST, default 16, SHALL set the maximum number of consecutive locked external grants.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the reset: synchronous, active-low (rst=0 resets on the next rising clk edge).
REQ-006 cpu_req / cpu_we / cpu_type  input  1 each  SHALL be the CPU access request, write enable, and byte(1)/word(0) select.
REQ-007 cpu_addr  input  ADDR_WIDTH  and  cpu_wdata  input  DATA_WIDTH  SHALL carry the CPU access address and store data.
REQ-008 cpu_gnt / cpu_rvalid  output  1 each  SHALL flag a CPU access issued this cycle and CPU read data valid.
REQ-009 cpu_rdata  output  DATA_WIDTH  and  cpu_stall  output  1  SHALL carry the CPU read data and the CPU hold request.
REQ-010 ext_req / ext_we / ext_type / ext_lock  input  1 each  SHALL be the external-requester access request, write enable, byte/word select, and burst-lock request.
REQ-011 ext_addr  input  ADDR_WIDTH  and  ext_wdata  input  DATA_WIDTH  SHALL carry the external access address and store data.
REQ-012 ext_gnt / ext_rvalid  output  1 each  and  ext_rdata  output  DATA_WIDTH  SHALL be the external grant, read-valid and read data.
REQ-013 mem_en / mem_we / mem_type  output  1 each  SHALL be the data-memory command strobe, write enable and byte/word select.
REQ-014 mem_addr  output  ADDR_WIDTH  and  mem_wdata  output  DATA_WIDTH  SHALL carry the data-memory address and store data.
REQ-015 mem_rdata  input  DATA_WIDTH  SHALL be the data-memory read data, valid one cycle after a read command.

Function
REQ-016 Grant SHALL be decided combinationally each cycle; at most one of cpu_gnt, ext_gnt SHALL be high, and a grant SHALL only be given to an asserted req.
REQ-017 mem_en SHALL equal cpu_gnt|ext_gnt; mem_we/type/addr/wdata SHALL mux from the granted requester in the same cycle; with no grant, mem_we=0 and other mem outputs are don't-care.
REQ-018 Priority: (1) ext while burst lock active; (2) with both requesting, the requester not granted last (register last_owner, reset to EXT so CPU wins first tie); (3) the sole requester.
REQ-019 Burst lock SHALL be active when ext_lock=1, ext_req=1, last_owner=EXT and burst_cnt<MAX_BURST.
REQ-020 burst_cnt SHALL increment on each ext_gnt with ext_lock=1, clear on any cycle without (ext_gnt & ext_lock), and clear after reaching MAX_BURST.
REQ-021 When burst_cnt reaches MAX_BURST, lock SHALL be void for the next cycle, so a waiting CPU is granted within MAX_BURST+1 cycles of requesting.
REQ-022 State machine: IDLE (no access last cycle), CPU_RD, EXT_RD, WR; next state from the issued command; rvalid of the owning port SHALL be 1 only in CPU_RD/EXT_RD, one cycle after the read grant.
REQ-023 cpu_rdata and ext_rdata SHALL both pass mem_rdata; only the matching rvalid qualifies it.
REQ-024 cpu_stall SHALL equal (cpu_req & ~cpu_gnt) | (CPU read granted last cycle is absent -- i.e., held) -- precisely: cpu_req&~cpu_gnt.
REQ-025 Back-to-back grants SHALL be allowed every cycle; a read issued at t and a new command at t+1 SHALL both complete.
REQ-026 Requester inputs SHALL be held stable by the requester until its gnt; the arbiter SHALL not buffer requests.

Reset
REQ-027 During rst=0: all gnt, rvalid, stall, mem_en, mem_we outputs SHALL be 0 in that cycle and after the edge; state=IDLE, last_owner=EXT, burst_cnt=0.
REQ-028 Reset asserted with a read outstanding SHALL drop its rvalid; no response SHALL be produced after reset release.

Structure
REQ-029 A shared package SHALL hold the arbiter state enum (IDLE, CPU_RD, EXT_RD, WR) and the owner encoding (OWN_CPU, OWN_EXT).
REQ-030 One sub-module, dmem_arb_prio, SHALL implement the combinational priority/lock decision; registers stay in dmem_arbiter.

Verification
REQ-031 CPU-only: cpu_req=1, we=0, addr=0x100, mem_rdata=0xDEADBEEF next cycle -> cpu_gnt=1 at t, cpu_rvalid=1 and cpu_rdata=0xDEADBEEF at t+1, cpu_stall=0.
REQ-032 Tie after reset: both req, reads -> cycle0 cpu_gnt, cycle1 ext_gnt, cycle2 cpu_gnt (alternation), cpu_stall=1 on cycle1 only.
REQ-033 Burst: ext_lock=1, ext_req=1 for 20 cycles, cpu_req=1 throughout, MAX_BURST=16 -> ext_gnt for 16 consecutive locked cycles, then cpu_gnt; CPU wait <=17 cycles.
REQ-034 Write: ext_we=1, type=1, addr=0x23, wdata=0xAB -> mem_en=1, mem_we=1, mem_type=1, mem_addr=0x23 same cycle; no rvalid next cycle.
REQ-035 Reset mid-read: CPU read granted at t, rst=0 at t+1 -> cpu_rvalid=0 at t+1 and t+2, all grants 0, first post-reset tie goes to CPU.
